// File: rtl/ghash_block.sv
// rtl/ghash_block.sv - digit-serial GHASH accumulator for AES-GCM
//
// Computes X_i = (X_{i-1} ^ B_i) * H in GF(2^128) with the GCM polynomial,
// consuming DIGIT multiplier bits per clock (128/DIGIT cycles per block).
// All 128-bit vectors use GCM bit order: [0:127], bit 0 = x^0 coefficient.
//
// Ports:
//   iClk           clock
//   iRstn          synchronous active-low reset
//   iInit          clear accumulator X, abort any multiply (H kept)
//   iH, iH_valid   hash key and its load strobe (honoured only in IDLE)
//   iBlock         data block B_i
//   iBlock_valid   block offered; taken when iBlock_valid & oReady
//   oReady         IDLE, H loaded and no iInit this cycle
//   oResult        current accumulator X
//   oResult_valid  one-cycle pulse when oResult takes a new X_i

module ghash_block #(
   parameter int DIGIT = 8
) (
   input  logic         iClk,
   input  logic         iRstn,
   input  logic         iInit,
   input  logic [0:127] iH,
   input  logic         iH_valid,
   input  logic [0:127] iBlock,
   input  logic         iBlock_valid,
   output logic         oReady,
   output logic [0:127] oResult,
   output logic         oResult_valid
);

   localparam int          NCYC     = 128 / DIGIT;
   localparam logic [6:0]  LAST_CNT = 7'(NCYC - 1);
   // Reduction constant R = 11100001 || 0^120 in GCM bit order.
   localparam logic [0:127] R_POLY  = 128'he1000000000000000000000000000000;

   typedef enum logic {S_IDLE, S_MULT} state_t;

   state_t       state_q, state_d;
   logic [0:127] x_q, x_d;
   logic [0:127] h_q, h_d;
   logic         h_loaded_q, h_loaded_d;
   logic [0:127] v_q, v_d;
   logic [0:127] y_q, y_d;
   logic [0:127] z_q, z_d;
   logic [6:0]   cnt_q, cnt_d;
   logic         valid_q, valid_d;

   logic [0:127] z_t;
   logic [0:127] v_t;
   logic [0:127] y_t;
   logic         ready;

   assign ready = (state_q == S_IDLE) & h_loaded_q & ~iInit;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      h_d        = h_q;
      h_loaded_d = h_loaded_q;
      v_d        = v_q;
      y_d        = y_q;
      z_d        = z_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;

      // One digit of the shift-and-add multiply. Y is shifted toward bit 0
      // each cycle, so the current digit always sits in Y[0:DIGIT-1].
      z_t = z_q;
      v_t = v_q;
      for (int k = 0; k < DIGIT; k++) begin
         if (y_q[7'(k)]) begin
            z_t = z_t ^ v_t;
         end
         v_t = v_t[127] ? ((v_t >> 1) ^ R_POLY) : (v_t >> 1);
      end
      y_t = y_q << DIGIT;

      case (state_q)
         S_IDLE: begin
            if (iH_valid) begin
               h_d        = iH;
               h_loaded_d = 1'b1;
            end
            if (iInit) begin
               x_d = '0;
            end else if (iBlock_valid && ready) begin
               // Multiply uses the H held before any same-cycle key load.
               v_d     = h_q;
               y_d     = x_q ^ iBlock;
               z_d     = '0;
               cnt_d   = '0;
               state_d = S_MULT;
            end
         end
         S_MULT: begin
            if (iInit) begin
               x_d     = '0;
               state_d = S_IDLE;
            end else if (cnt_q == LAST_CNT) begin
               x_d     = z_t;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               v_d   = v_t;
               y_d   = y_t;
               z_d   = z_t;
               cnt_d = cnt_q + 7'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRstn) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         h_q        <= '0;
         h_loaded_q <= 1'b0;
         v_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         h_q        <= h_d;
         h_loaded_q <= h_loaded_d;
         v_q        <= v_d;
         y_q        <= y_d;
         z_q        <= z_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
      end
   end

   assign oReady        = ready;
   assign oResult       = x_q;
   assign oResult_valid = valid_q;

endmodule

// File: tb/tb_ghash_block.sv
// tb/tb_ghash_block.sv - directed self-checking bench for ghash_block

module tb_ghash_block;

   localparam logic [0:127] H_ID  = 128'h80000000000000000000000000000000;
   localparam logic [0:127] B_T2  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [0:127] H_TC2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [0:127] B1    = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [0:127] X1    = 128'h5e2ec746917062882c85b0685353deb7;
   localparam logic [0:127] B2    = 128'h00000000000000000000000000000080;
   localparam logic [0:127] X2    = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [0:127] H_BAD = 128'hdeadbeefcafef00d0badc0de12345678;

   logic         iClk = 1'b0;
   logic         iRstn;
   logic         iInit;
   logic [0:127] iH;
   logic         iH_valid;
   logic [0:127] iBlock;
   logic         iBlock_valid;
   logic         oReady;
   logic [0:127] oResult;
   logic         oResult_valid;

   logic [3:0]   sw_hv;
   logic [3:0]   sw_bv;
   logic [0:127] sw_h;
   logic [0:127] sw_blk;
   logic [3:0]   sw_rdy;
   logic [0:127] sw_res [4];
   logic [3:0]   sw_rv;

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   ghash_block #(.DIGIT(8)) dut (
      .iClk          (iClk),
      .iRstn         (iRstn),
      .iInit         (iInit),
      .iH            (iH),
      .iH_valid      (iH_valid),
      .iBlock        (iBlock),
      .iBlock_valid  (iBlock_valid),
      .oReady        (oReady),
      .oResult       (oResult),
      .oResult_valid (oResult_valid)
   );

   for (genvar g = 0; g < 4; g++) begin : g_sw
      ghash_block #(.DIGIT(g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 8 : 32)) u_sw (
         .iClk          (iClk),
         .iRstn         (iRstn),
         .iInit         (1'b0),
         .iH            (sw_h),
         .iH_valid      (sw_hv[g]),
         .iBlock        (sw_blk),
         .iBlock_valid  (sw_bv[g]),
         .oReady        (sw_rdy[g]),
         .oResult       (sw_res[g]),
         .oResult_valid (sw_rv[g])
      );
   end

   task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (oResult_valid !== 1'b1 && lat < 300) begin
         tick();
         lat++;
      end
      if (oResult_valid !== 1'b1) lat = -1;
   endtask

   task automatic send(input logic [0:127] b);
      iBlock       = b;
      iBlock_valid = 1'b1;
      tick();
      iBlock_valid = 1'b0;
   endtask

   task automatic count_pulses(output int n);
      n = 0;
      repeat (20) begin
         tick();
         if (oResult_valid === 1'b1) n++;
      end
   endtask

   initial begin
      int lat;
      int n;
      int dg;

      iRstn = 1'b0; iInit = 1'b0; iH = '0; iH_valid = 1'b0;
      iBlock = '0; iBlock_valid = 1'b0;
      sw_hv = '0; sw_bv = '0; sw_h = '0; sw_blk = '0;

      // T1 reset and no acceptance before H is loaded
      repeat (3) tick();
      chk("rst_result", oResult, '0);
      chk("rst_ready", 128'(oReady), '0);
      chk("rst_valid", 128'(oResult_valid), '0);
      iRstn = 1'b1;
      iBlock = B_T2; iBlock_valid = 1'b1;
      repeat (3) tick();
      chk("noh_ready", 128'(oReady), '0);
      iBlock_valid = 1'b0;
      count_pulses(n);
      chk("noh_pulses", 128'(n), '0);
      chk("noh_result", oResult, '0);

      // T2 identity key
      iH = H_ID; iH_valid = 1'b1;
      tick();
      iH_valid = 1'b0;
      chk("hload_ready", 128'(oReady), 128'(1));
      send(B_T2);
      chk("mult_ready", 128'(oReady), '0);
      wait_valid(lat);
      chk("t2_lat", 128'(lat), 128'(16));
      chk("t2_result", oResult, B_T2);
      tick();
      chk("t2_pulse_width", 128'(oResult_valid), '0);
      chk("t2_hold", oResult, B_T2);

      // T3 GCM test case 2
      iInit = 1'b1; iH = H_TC2; iH_valid = 1'b1;
      #1;
      chk("init_ready", 128'(oReady), '0);
      tick();
      iInit = 1'b0; iH_valid = 1'b0;
      chk("t3_init_x", oResult, '0);
      send(B1);
      wait_valid(lat);
      chk("t3_lat", 128'(lat), 128'(16));
      chk("t3_x1", oResult, X1);
      tick();
      send(B2);
      wait_valid(lat);
      chk("t3_x2", oResult, X2);
      tick();

      // T4 abort mid-multiply
      iInit = 1'b1; tick(); iInit = 1'b0;
      send(B1);
      repeat (4) tick();
      iInit = 1'b1; tick(); iInit = 1'b0;
      #1;
      chk("abort_x", oResult, '0);
      chk("abort_valid", 128'(oResult_valid), '0);
      chk("abort_ready", 128'(oReady), 128'(1));
      count_pulses(n);
      chk("abort_pulses", 128'(n), '0);
      send(B1);
      wait_valid(lat);
      chk("abort_rerun_x1", oResult, X1);

      // T5 back-to-back in the pulse cycle, garbage H during MULT
      chk("b2b_ready", 128'(oReady), 128'(1));
      send(B2);
      tick();
      iH = H_BAD; iH_valid = 1'b1; tick(); iH_valid = 1'b0;
      wait_valid(lat);
      chk("b2b_x2", oResult, X2);
      tick();
      iInit = 1'b1; tick(); iInit = 1'b0;
      send(B1);
      wait_valid(lat);
      chk("hkept_x1", oResult, X1);
      tick();

      // Key load and block in the same IDLE cycle: block uses the old key
      iInit = 1'b1; tick(); iInit = 1'b0;
      iH = H_ID; iH_valid = 1'b1; iBlock = B1; iBlock_valid = 1'b1;
      tick();
      iH_valid = 1'b0; iBlock_valid = 1'b0;
      wait_valid(lat);
      chk("simul_oldh_x1", oResult, X1);
      tick();
      iInit = 1'b1; tick(); iInit = 1'b0;
      send(B_T2);
      wait_valid(lat);
      chk("simul_newh", oResult, B_T2);
      tick();

      // iInit beats iBlock_valid in IDLE
      iInit = 1'b1; iBlock = B1; iBlock_valid = 1'b1;
      #1;
      chk("initbeat_ready", 128'(oReady), '0);
      tick();
      iInit = 1'b0; iBlock_valid = 1'b0;
      chk("initbeat_x", oResult, '0);
      count_pulses(n);
      chk("initbeat_pulses", 128'(n), '0);

      // iInit on the completion cycle
      send(B_T2);
      repeat (15) tick();
      chk("compl_pre_valid", 128'(oResult_valid), '0);
      iInit = 1'b1; tick(); iInit = 1'b0;
      chk("compl_valid", 128'(oResult_valid), '0);
      chk("compl_x", oResult, '0);
      count_pulses(n);
      chk("compl_pulses", 128'(n), '0);

      // Reset mid-multiply clears the key as well
      send(B_T2);
      repeat (3) tick();
      iRstn = 1'b0; tick(); iRstn = 1'b1;
      #1;
      chk("rstmid_ready", 128'(oReady), '0);
      chk("rstmid_x", oResult, '0);
      count_pulses(n);
      chk("rstmid_pulses", 128'(n), '0);

      // T6 DIGIT sweep on GCM test case 2
      for (int j = 0; j < 4; j++) begin
         dg = (j == 0) ? 1 : (j == 1) ? 4 : (j == 2) ? 8 : 32;
         sw_h = H_TC2; sw_hv[j] = 1'b1; tick(); sw_hv[j] = 1'b0;
         sw_blk = B1; sw_bv[j] = 1'b1; tick(); sw_bv[j] = 1'b0;
         lat = 0;
         while (sw_rv[j] !== 1'b1 && lat < 300) begin tick(); lat++; end
         if (sw_rv[j] !== 1'b1) lat = -1;
         chk($sformatf("sweep%0d_lat1", dg), 128'(lat), 128'(128 / dg));
         chk($sformatf("sweep%0d_x1", dg), sw_res[j], X1);
         tick();
         sw_blk = B2; sw_bv[j] = 1'b1; tick(); sw_bv[j] = 1'b0;
         lat = 0;
         while (sw_rv[j] !== 1'b1 && lat < 300) begin tick(); lat++; end
         if (sw_rv[j] !== 1'b1) lat = -1;
         chk($sformatf("sweep%0d_lat2", dg), 128'(lat), 128'(128 / dg));
         chk($sformatf("sweep%0d_x2", dg), sw_res[j], X2);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
